// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: register offsets and field widths.
package irq_ctrl_pkg;
  localparam logic [31:0] IRQ_ENABLE  = 32'h00;
  localparam logic [31:0] IRQ_PENDING = 32'h04;
  localparam logic [31:0] IRQ_MODE    = 32'h08;
  localparam logic [31:0] IRQ_CLAIM   = 32'h0C;
  localparam logic [31:0] IRQ_COUNT   = 32'h10;

  localparam int COUNT_W  = 8;
  localparam int NSRC_MAX = 8;
endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder; id is 1-based so 0 can mean "nothing active".
module irq_prio_enc #(
  parameter int NSRC = 4
) (
  input  logic [NSRC-1:0] req_i,
  output logic            valid_o,
  output logic [3:0]      id_o
);
  always_comb begin
    valid_o = 1'b0;
    id_o    = 4'd0;
    // Scan downwards so the lowest active index is the last one written.
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        id_o    = 4'(i + 1);
      end
    end
  end
endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge/level event capture, W1C pending, per-source enable,
// source-0 event counter and a claim register, on the timer_ip style slave bus.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NSRC = 4
) (
  input  logic            clk_i,
  input  logic            resetn_i,
  input  logic            sel_i,
  input  logic            we_i,
  input  logic [31:0]     addr_i,
  input  logic [31:0]     wdata_i,
  output logic [31:0]     rdata_o,
  input  logic [NSRC-1:0] src_in_i,
  output logic            irq_o
);
  logic [NSRC-1:0]    enable_q, enable_d;
  logic [NSRC-1:0]    pending_q, pending_d;
  logic [NSRC-1:0]    mode_q, mode_d;
  logic [NSRC-1:0]    src_q, src_d;
  logic [COUNT_W-1:0] count_q, count_d, count_base;
  logic [NSRC-1:0]    evt, clr;
  logic               wr, wr_en, wr_pend, wr_mode, wr_cnt;
  logic               claim_valid;
  logic [3:0]         claim_id;
  logic               unused_bits;

  assign unused_bits = ^{addr_i[31:5], addr_i[1:0], wdata_i[31:NSRC]};

  assign wr      = sel_i && we_i;
  assign wr_en   = wr && (addr_i[4:2] == IRQ_ENABLE[4:2]);
  assign wr_pend = wr && (addr_i[4:2] == IRQ_PENDING[4:2]);
  assign wr_mode = wr && (addr_i[4:2] == IRQ_MODE[4:2]);
  assign wr_cnt  = wr && (addr_i[4:2] == IRQ_COUNT[4:2]);

  // Level sources follow the pin; edge sources fire only on a 0->1 transition.
  assign evt = (mode_q & src_in_i) | (~mode_q & src_in_i & ~src_q);
  assign clr = wr_pend ? wdata_i[NSRC-1:0] : '0;

  always_comb begin
    enable_d   = wr_en   ? wdata_i[NSRC-1:0] : enable_q;
    mode_d     = wr_mode ? wdata_i[NSRC-1:0] : mode_q;
    pending_d  = (pending_q & ~clr) | evt;
    src_d      = src_in_i;
    count_base = wr_cnt ? '0 : count_q;
    count_d    = count_base;
    if (evt[0] && (count_base != '1)) begin
      count_d = count_base + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      enable_q  <= '0;
      pending_q <= '0;
      mode_q    <= '0;
      src_q     <= '1;
      count_q   <= '0;
    end else begin
      enable_q  <= enable_d;
      pending_q <= pending_d;
      mode_q    <= mode_d;
      src_q     <= src_d;
      count_q   <= count_d;
    end
  end

  irq_prio_enc #(.NSRC(NSRC)) u_prio_enc (
    .req_i   (pending_q & enable_q),
    .valid_o (claim_valid),
    .id_o    (claim_id)
  );

  assign irq_o = |(pending_q & enable_q);

  always_comb begin
    rdata_o = '0;
    if (sel_i && !we_i) begin
      case (addr_i[4:2])
        IRQ_ENABLE[4:2]:  rdata_o[NSRC-1:0]    = enable_q;
        IRQ_PENDING[4:2]: rdata_o[NSRC-1:0]    = pending_q;
        IRQ_MODE[4:2]:    rdata_o[NSRC-1:0]    = mode_q;
        IRQ_CLAIM[4:2]:   rdata_o[3:0]         = claim_valid ? claim_id : 4'd0;
        IRQ_COUNT[4:2]:   rdata_o[COUNT_W-1:0] = count_q;
        default:          rdata_o              = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a per-source behavioural model.
module tb_irq_ctrl;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          sel, we;
  logic [31:0]   addr, wdata;
  logic [31:0]   rdata;
  logic [N-1:0]  src;
  logic          irq;

  int n_vec = 0;
  int n_err = 0;
  bit check_en = 0;

  // Model state, one entry per source
  bit m_pend[8], m_en[8], m_mode[8], m_prev[8];
  int m_cnt;
  bit ev[8];
  bit m_wr;
  int m_idx;

  irq_ctrl #(.NSRC(N)) dut (
    .clk_i    (clk),
    .resetn_i (resetn),
    .sel_i    (sel),
    .we_i     (we),
    .addr_i   (addr),
    .wdata_i  (wdata),
    .rdata_o  (rdata),
    .src_in_i (src),
    .irq_o    (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 8; i++) begin
        m_pend[i] = 0; m_en[i] = 0; m_mode[i] = 0; m_prev[i] = 1;
      end
      m_cnt = 0;
    end else begin
      m_wr  = sel && we;
      m_idx = int'((addr >> 2) & 32'h7);
      for (int i = 0; i < N; i++)
        ev[i] = m_mode[i] ? src[i] : (src[i] && !m_prev[i]);
      for (int i = 0; i < N; i++) begin
        if (m_wr && m_idx == 1 && wdata[i]) m_pend[i] = 0;
        if (ev[i]) m_pend[i] = 1;
        if (m_wr && m_idx == 0) m_en[i] = wdata[i];
        if (m_wr && m_idx == 2) m_mode[i] = wdata[i];
        m_prev[i] = src[i];
      end
      if (m_wr && m_idx == 4) m_cnt = 0;
      if (ev[0] && m_cnt < 255) m_cnt = m_cnt + 1;
    end
  end

  function automatic bit m_irq();
    bit r = 0;
    for (int i = 0; i < N; i++) if (m_pend[i] && m_en[i]) r = 1;
    return r;
  endfunction

  function automatic logic [31:0] m_read();
    logic [31:0] r = '0;
    int idx = int'((addr >> 2) & 32'h7);
    if (!sel || we) return '0;
    case (idx)
      0: for (int i = 0; i < N; i++) r[i] = m_en[i];
      1: for (int i = 0; i < N; i++) r[i] = m_pend[i];
      2: for (int i = 0; i < N; i++) r[i] = m_mode[i];
      3: for (int i = N - 1; i >= 0; i--) if (m_pend[i] && m_en[i]) r = 32'(i + 1);
      4: r = 32'(m_cnt);
      default: r = '0;
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      n_vec++;
      if (irq !== m_irq()) begin
        n_err++;
        $display("FAIL irq t=%0t got %b expected %b", $time, irq, m_irq());
      end
      n_vec++;
      if (rdata !== m_read()) begin
        n_err++;
        $display("FAIL rdata t=%0t addr=%h got %h expected %h", $time, addr, rdata, m_read());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    sel = 1; we = 1; addr = a; wdata = d;
    cyc();
    sel = 0; we = 0;
  endtask

  task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    sel = 1; we = 0; addr = a;
    #1;
    chk(name, rdata, exp);
    cyc();
    sel = 0;
  endtask

  initial begin
    resetn = 0; sel = 0; we = 0; addr = '0; wdata = '0; src = '0;
    cyc(); cyc();
    check_en = 1;
    chk("reset_irq", {31'b0, irq}, 32'd0);
    read_chk("reset_enable", 32'h00, 32'h0);
    resetn = 1;

    // One-shot timer pulse on source 0
    bus_write(32'h00, 32'h1);
    src = 4'b0001; cyc(); src = 4'b0000;
    chk("oneshot_irq", {31'b0, irq}, 32'd1);
    read_chk("oneshot_pending", 32'h04, 32'h1);
    read_chk("oneshot_claim", 32'h0C, 32'h1);
    read_chk("oneshot_count", 32'h10, 32'h1);
    bus_write(32'h04, 32'h1);
    chk("oneshot_w1c_irq", {31'b0, irq}, 32'd0);

    // Periodic pulses while masked
    bus_write(32'h00, 32'h0);
    bus_write(32'h10, 32'h0);
    for (int k = 0; k < 40; k++) begin
      src = (k % 5 == 4) ? 4'b0001 : 4'b0000;
      cyc();
    end
    src = 4'b0000;
    read_chk("periodic_pending", 32'h04, 32'h1);
    chk("periodic_irq_masked", {31'b0, irq}, 32'd0);
    read_chk("periodic_count", 32'h10, 32'd8);
    bus_write(32'h00, 32'h1);
    chk("periodic_enable_irq", {31'b0, irq}, 32'd1);

    // Simultaneous sources 0 and 2, priority
    bus_write(32'h04, 32'hF);
    bus_write(32'h00, 32'h5);
    src = 4'b0101; cyc(); src = 4'b0000;
    read_chk("prio_claim_a", 32'h0C, 32'd1);
    bus_write(32'h04, 32'h1);
    read_chk("prio_claim_b", 32'h0C, 32'd3);
    bus_write(32'h04, 32'h4);
    chk("prio_irq_low", {31'b0, irq}, 32'd0);
    read_chk("prio_claim_c", 32'h0C, 32'd0);

    // Level mode on source 1
    bus_write(32'h08, 32'h2);
    src = 4'b0010;
    bus_write(32'h00, 32'h2);
    bus_write(32'h04, 32'h2);
    chk("level_irq_held", {31'b0, irq}, 32'd1);
    read_chk("level_pending_held", 32'h04, 32'h2);
    src = 4'b0000; cyc();
    bus_write(32'h04, 32'h2);
    chk("level_irq_cleared", {31'b0, irq}, 32'd0);
    bus_write(32'h08, 32'h0);

    // Set beats clear; counter saturation and clear
    src = 4'b0001;
    bus_write(32'h04, 32'h1);
    src = 4'b0000;
    read_chk("set_wins", 32'h04, 32'h1);
    bus_write(32'h10, 32'h0);
    for (int k = 0; k < 256; k++) begin
      src = 4'b0001; cyc();
      src = 4'b0000; cyc();
    end
    read_chk("count_sat", 32'h10, 32'd255);
    bus_write(32'h10, 32'h0);
    read_chk("count_clear", 32'h10, 32'd0);
    src = 4'b0001;
    bus_write(32'h10, 32'h0);
    src = 4'b0000;
    read_chk("count_clear_evt", 32'h10, 32'd1);

    // Input held high through reset release
    src = 4'b1000;
    resetn = 0; cyc(); cyc();
    resetn = 1; cyc(); cyc();
    read_chk("held_through_reset", 32'h04, 32'h0);
    src = 4'b0000;

    // Reset mid-run with irq asserted
    bus_write(32'h00, 32'h1);
    src = 4'b0001; cyc(); src = 4'b0000;
    chk("pre_reset_irq", {31'b0, irq}, 32'd1);
    resetn = 0; cyc();
    chk("mid_reset_irq", {31'b0, irq}, 32'd0);
    read_chk("mid_reset_enable", 32'h00, 32'h0);
    resetn = 1;
    read_chk("post_reset_pending", 32'h04, 32'h0);
    read_chk("post_reset_count", 32'h10, 32'h0);

    // Random traffic
    for (int k = 0; k < 4000; k++) begin
      resetn = ($urandom_range(0, 255) != 0);
      sel    = $urandom_range(0, 1) != 0;
      we     = $urandom_range(0, 2) == 0;
      addr   = $urandom();
      if ($urandom_range(0, 3) != 0) addr = addr & 32'h1F;
      wdata  = $urandom();
      if ($urandom_range(0, 1) != 0) wdata = wdata & 32'hF;
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 3) == 0) src[b] = ~src[b];
      cyc();
    end
    sel = 0; we = 0; resetn = 1;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
